// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_if
// Purpose : pipeline-side hazard/forwarding bundle for hazard_ctrl
// Rev     : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int AW  = 5,
  parameter int NRS = 2,
  parameter int CW  = 16
);
  logic [NRS*AW-1:0] rs_addrD;
  logic [NRS-1:0]    rs_useD;
  logic [NRS*AW-1:0] rs_addrE;
  logic [AW-1:0]     rd_addrE;
  logic [AW-1:0]     rd_addrM;
  logic [AW-1:0]     rd_addrW;
  logic              rd_wrenE;
  logic              rd_wrenM;
  logic              rd_wrenW;
  logic              loadE;
  logic              br_takenE;
  logic              mc_startE;
  logic              mem_busyM;
  logic              cnt_clr;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic [NRS*2-1:0]  fwd_sel;
  logic              mc_busy;
  logic [CW-1:0]     stall_cnt;

  modport master (
    output rs_addrD, rs_useD, rs_addrE, rd_addrE, rd_addrM, rd_addrW,
           rd_wrenE, rd_wrenM, rd_wrenW, loadE, br_takenE, mc_startE,
           mem_busyM, cnt_clr,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM,
           fwd_sel, mc_busy, stall_cnt
  );

  modport slave (
    input  rs_addrD, rs_useD, rs_addrE, rd_addrE, rd_addrM, rd_addrW,
           rd_wrenE, rd_wrenM, rd_wrenW, loadE, br_takenE, mc_startE,
           mem_busyM, cnt_clr,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM,
           fwd_sel, mc_busy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Purpose : 5-stage pipeline interlock, forwarding select and multi-cycle stall
// Rev     : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int AW     = 5,
  parameter int NRS    = 2,
  parameter int FWD_EN = 1,
  parameter int MC_LAT = 4,
  parameter int CW     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [0:0]    c_IDLE    = 1'b0;
  localparam logic [0:0]    c_BUSY    = 1'b1;
  localparam logic          c_MC_EN   = (MC_LAT > 0) ? 1'b1 : 1'b0;
  localparam logic [3:0]    c_LAT_M1  = (MC_LAT > 0) ? 4'(MC_LAT - 1) : 4'd0;
  localparam logic [CW-1:0] c_CNT_MAX = '1;

  logic [0:0]    r_state;
  logic [3:0]    r_cnt;
  logic [CW-1:0] r_stall_cnt;
  logic [NRS-1:0] w_raw;
  logic          w_raw_any;
  logic          w_mc_stall;
  logic          w_stallF, w_stallD, w_stallE, w_stallM;
  logic          w_flushD, w_flushE, w_flushM;

  for (genvar i = 0; i < NRS; i++) begin : g_port
    logic [AW-1:0] w_srcD;
    logic [AW-1:0] w_srcE;
    logic          w_fwdM, w_fwdW;
    logic          w_dE, w_dM, w_dW, w_vD;

    assign w_srcD = bus.rs_addrD[i*AW +: AW];
    assign w_srcE = bus.rs_addrE[i*AW +: AW];

    // r0 is hardwired zero, so it never forwards and never interlocks
    assign w_fwdM = (w_srcE != '0) && bus.rd_wrenM && (w_srcE == bus.rd_addrM);
    assign w_fwdW = (w_srcE != '0) && bus.rd_wrenW && (w_srcE == bus.rd_addrW);
    assign bus.fwd_sel[i*2 +: 2] = (FWD_EN == 0) ? 2'b00 :
                                   w_fwdM        ? 2'b01 :
                                   w_fwdW        ? 2'b10 : 2'b00;

    assign w_vD = bus.rs_useD[i] && (w_srcD != '0);
    assign w_dE = bus.rd_wrenE && (w_srcD == bus.rd_addrE);
    assign w_dM = bus.rd_wrenM && (w_srcD == bus.rd_addrM);
    assign w_dW = bus.rd_wrenW && (w_srcD == bus.rd_addrW);
    assign w_raw[i] = w_vD && ((FWD_EN != 0) ? (bus.loadE && w_dE)
                                             : (w_dE || w_dM || w_dW));
  end

  assign w_raw_any  = |w_raw;
  assign w_mc_stall = ((r_state == c_IDLE) && bus.mc_startE && c_MC_EN) ||
                      ((r_state == c_BUSY) && (r_cnt != 4'd0));

  always_comb begin
    w_stallF = 1'b0;
    w_stallD = 1'b0;
    w_stallE = 1'b0;
    w_stallM = 1'b0;
    w_flushD = 1'b0;
    w_flushE = 1'b0;
    w_flushM = 1'b0;
    if (bus.mem_busyM) begin
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_stallE = 1'b1;
      w_stallM = 1'b1;
    end else if (w_mc_stall) begin
      // E holds the multi-cycle op; a bubble goes down to M meanwhile
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_stallE = 1'b1;
      w_flushM = 1'b1;
    end else if (bus.br_takenE) begin
      w_flushD = 1'b1;
      w_flushE = 1'b1;
    end else if (w_raw_any) begin
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_flushE = 1'b1;
    end
  end

  assign bus.stallF    = w_stallF;
  assign bus.stallD    = w_stallD;
  assign bus.stallE    = w_stallE;
  assign bus.stallM    = w_stallM;
  assign bus.flushD    = w_flushD;
  assign bus.flushE    = w_flushE;
  assign bus.flushM    = w_flushM;
  assign bus.mc_busy   = (r_state == c_BUSY);
  assign bus.stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
    end else if (!bus.mem_busyM) begin
      case (r_state)
        c_IDLE: begin
          if (bus.mc_startE && c_MC_EN) begin
            r_state <= c_BUSY;
            r_cnt   <= c_LAT_M1;
          end
        end
        c_BUSY: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else               r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (bus.cnt_clr)
      r_stall_cnt <= '0;
    else if (w_stallF && (r_stall_cnt != c_CNT_MAX))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Bench for hazard_ctrl: two instances (forwarding/MC_LAT=4/CW=16 and
// interlock-only/MC_LAT=2/CW=4) driven together, directed scenarios then random vs a model.
module tb_hazard_ctrl;
  localparam int AW  = 5;
  localparam int NRS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NRS*AW-1:0] rs_addrD, rs_addrE;
  logic [NRS-1:0]    rs_useD;
  logic [AW-1:0]     rd_addrE, rd_addrM, rd_addrW;
  logic rd_wrenE, rd_wrenM, rd_wrenW, loadE, br_takenE, mc_startE, mem_busyM, cnt_clr;

  int checks = 0;
  int errors = 0;

  // model state per instance: ph = remaining BUSY cycles (0 = idle)
  int ph [2];
  int scnt [2];
  int fe_k [2]  = '{1, 0};
  int lat_k [2] = '{4, 2};
  int max_k [2] = '{65535, 15};

  hazard_ctrl_if #(.AW(AW), .NRS(NRS), .CW(16)) bus ();
  hazard_ctrl_if #(.AW(AW), .NRS(NRS), .CW(4))  bus0 ();

  hazard_ctrl #(.AW(AW), .NRS(NRS), .FWD_EN(1), .MC_LAT(4), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  hazard_ctrl #(.AW(AW), .NRS(NRS), .FWD_EN(0), .MC_LAT(2), .CW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  assign bus.rs_addrD  = rs_addrD;   assign bus0.rs_addrD  = rs_addrD;
  assign bus.rs_useD   = rs_useD;    assign bus0.rs_useD   = rs_useD;
  assign bus.rs_addrE  = rs_addrE;   assign bus0.rs_addrE  = rs_addrE;
  assign bus.rd_addrE  = rd_addrE;   assign bus0.rd_addrE  = rd_addrE;
  assign bus.rd_addrM  = rd_addrM;   assign bus0.rd_addrM  = rd_addrM;
  assign bus.rd_addrW  = rd_addrW;   assign bus0.rd_addrW  = rd_addrW;
  assign bus.rd_wrenE  = rd_wrenE;   assign bus0.rd_wrenE  = rd_wrenE;
  assign bus.rd_wrenM  = rd_wrenM;   assign bus0.rd_wrenM  = rd_wrenM;
  assign bus.rd_wrenW  = rd_wrenW;   assign bus0.rd_wrenW  = rd_wrenW;
  assign bus.loadE     = loadE;      assign bus0.loadE     = loadE;
  assign bus.br_takenE = br_takenE;  assign bus0.br_takenE = br_takenE;
  assign bus.mc_startE = mc_startE;  assign bus0.mc_startE = mc_startE;
  assign bus.mem_busyM = mem_busyM;  assign bus0.mem_busyM = mem_busyM;
  assign bus.cnt_clr   = cnt_clr;    assign bus0.cnt_clr   = cnt_clr;

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushM}
  logic [6:0]  act_ctl [2];
  logic [3:0]  act_fwd [2];
  logic        act_busy [2];
  logic [15:0] act_cnt [2];
  assign act_ctl[0] = {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
                       bus.flushD, bus.flushE, bus.flushM};
  assign act_ctl[1] = {bus0.stallF, bus0.stallD, bus0.stallE, bus0.stallM,
                       bus0.flushD, bus0.flushE, bus0.flushM};
  assign act_fwd[0]  = bus.fwd_sel;
  assign act_fwd[1]  = bus0.fwd_sel;
  assign act_busy[0] = bus.mc_busy;
  assign act_busy[1] = bus0.mc_busy;
  assign act_cnt[0]  = bus.stall_cnt;
  assign act_cnt[1]  = {12'd0, bus0.stall_cnt};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] m_ctl(input int k);
    logic raw;
    logic mc;
    logic [AW-1:0] a;
    raw = 1'b0;
    for (int i = 0; i < NRS; i++) begin
      a = rs_addrD[i*AW +: AW];
      if (rs_useD[i] && a != 0) begin
        if (fe_k[k] != 0)
          raw |= loadE && rd_wrenE && (a == rd_addrE);
        else
          raw |= (rd_wrenE && a == rd_addrE) || (rd_wrenM && a == rd_addrM) ||
                 (rd_wrenW && a == rd_addrW);
      end
    end
    mc = (ph[k] == 0 && mc_startE && lat_k[k] > 0) || (ph[k] > 1);
    if (mem_busyM) return 7'b1111_000;
    if (mc)        return 7'b1110_001;
    if (br_takenE) return 7'b0000_110;
    if (raw)       return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  function automatic logic [3:0] m_fwd(input int k);
    logic [3:0] r;
    logic [AW-1:0] a;
    r = '0;
    for (int i = 0; i < NRS; i++) begin
      a = rs_addrE[i*AW +: AW];
      if (fe_k[k] != 0 && a != 0) begin
        if (rd_wrenM && a == rd_addrM)      r[i*2 +: 2] = 2'b01;
        else if (rd_wrenW && a == rd_addrW) r[i*2 +: 2] = 2'b10;
      end
    end
    return r;
  endfunction

  task automatic clear_inputs();
    rs_addrD = '0; rs_addrE = '0; rs_useD = '0;
    rd_addrE = '0; rd_addrM = '0; rd_addrW = '0;
    rd_wrenE = 0; rd_wrenM = 0; rd_wrenW = 0; loadE = 0;
    br_takenE = 0; mc_startE = 0; mem_busyM = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (act_busy[0] !== 1'b0 || act_cnt[0] !== 16'd0 || act_ctl[0] !== 7'd0 || act_fwd[0] !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b cnt=%0d ctl=%b fwd=%b required 0/0/0/0",
               act_busy[0], act_cnt[0], act_ctl[0], act_fwd[0]);
    end
    mc_startE = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (act_ctl[0] !== 7'b1110_001 || act_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: ctl=%b busy=%b required 1110001/0", act_ctl[0], act_busy[0]);
    end
    mc_startE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    do_reset();
    @(negedge clk);
    rs_addrE[0 +: AW] = 5; rd_addrM = 5; rd_wrenM = 1; rd_addrW = 5; rd_wrenW = 1;
    #1;
    checks++;
    if (act_fwd[0] !== 4'b0001 || act_fwd[1] !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_m_wins: got %b/%b required 0001/0000", act_fwd[0], act_fwd[1]);
    end
    rs_addrE[0 +: AW] = 0;
    #1;
    checks++;
    if (act_fwd[0] !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_r0: got %b required 0000", act_fwd[0]);
    end
    rs_addrE[0 +: AW] = 5; rs_addrE[AW +: AW] = 5; rd_wrenM = 0;
    #1;
    checks++;
    if (act_fwd[0] !== 4'b1010) begin
      errors++;
      $display("FAIL fwd_w: got %b required 1010", act_fwd[0]);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    loadE = 1; rd_wrenE = 1; rd_addrE = 7; rs_addrD[AW +: AW] = 7; rs_useD = 2'b10;
    #1;
    checks++;
    if (act_ctl[0] !== 7'b1100_010 || act_ctl[1] !== 7'b1100_010) begin
      errors++;
      $display("FAIL load_use: got %b/%b required 1100010", act_ctl[0], act_ctl[1]);
    end
    rs_useD = 2'b00;
    #1;
    checks++;
    if (act_ctl[0] !== 7'd0 || act_ctl[1] !== 7'd0) begin
      errors++;
      $display("FAIL load_use_unused: got %b/%b required 0000000", act_ctl[0], act_ctl[1]);
    end
    // non-load producer in M: interlock-only instance stalls, forwarding one does not
    rs_useD = 2'b10; loadE = 0; rd_wrenE = 0; rd_addrM = 7; rd_wrenM = 1;
    #1;
    checks++;
    if (act_ctl[0] !== 7'd0 || act_ctl[1] !== 7'b1100_010) begin
      errors++;
      $display("FAIL raw_nofwd_m: got %b/%b required 0000000/1100010", act_ctl[0], act_ctl[1]);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    loadE = 1; rd_wrenE = 1; rd_addrE = 7; rs_addrD[AW +: AW] = 7; rs_useD = 2'b10; br_takenE = 1;
    #1;
    checks++;
    if (act_ctl[0] !== 7'b0000_110) begin
      errors++;
      $display("FAIL branch_over_loaduse: got %b required 0000110", act_ctl[0]);
    end
    clear_inputs();
  endtask

  task automatic test_multicycle();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mc_startE = 1;
      #1;
      checks++;
      if (act_ctl[0] !== 7'b1110_001) begin
        errors++;
        $display("FAIL mc_stall cyc%0d: got %b required 1110001", c, act_ctl[0]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (act_ctl[0] !== 7'd0 || act_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mc_complete: ctl=%b busy=%b required 0000000/1", act_ctl[0], act_busy[0]);
    end
    @(negedge clk);
    mc_startE = 0;
    #1;
    checks++;
    if (act_busy[0] !== 1'b0 || act_cnt[0] !== 16'd4) begin
      errors++;
      $display("FAIL mc_done: busy=%b stall_cnt=%0d required 0/4", act_busy[0], act_cnt[0]);
    end
  endtask

  task automatic test_mem_freeze();
    int nm = 0;
    int cyc = 0;
    bit done = 0;
    do_reset();
    while (!done && cyc < 20) begin
      @(negedge clk);
      mc_startE = 1;
      mem_busyM = (cyc >= 2 && cyc <= 4);
      #1;
      if (mem_busyM) begin
        checks++;
        if (act_ctl[0] !== 7'b1111_000 || act_busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL mem_freeze cyc%0d: ctl=%b busy=%b required 1111000/1", cyc, act_ctl[0], act_busy[0]);
        end
      end else if (act_ctl[0][4]) begin
        nm++;
      end else if (act_busy[0]) begin
        done = 1;
      end
      cyc++;
    end
    checks++;
    if (!done || nm != 4) begin
      errors++;
      $display("FAIL mem_freeze_total: done=%0d mc_stall_cycles=%0d required 1/4", done, nm);
    end
    @(negedge clk);
    mc_startE = 0; mem_busyM = 0;
    #1;
    checks++;
    if (act_busy[0] !== 1'b0 || act_cnt[0] !== 16'd7) begin
      errors++;
      $display("FAIL mem_freeze_cnt: busy=%b stall_cnt=%0d required 0/7", act_busy[0], act_cnt[0]);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    @(negedge clk);
    mc_startE = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (act_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre: busy=%b required 1", act_busy[0]);
    end
    rst_n = 0; mc_startE = 0;
    #1;
    checks++;
    if (act_busy[0] !== 1'b0 || act_cnt[0] !== 16'd0) begin
      errors++;
      $display("FAIL rst_busy_async: busy=%b stall_cnt=%0d required 0/0", act_busy[0], act_cnt[0]);
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (act_ctl[0] !== 7'd0 || act_busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy_after cyc%0d: ctl=%b busy=%b required 0000000/0", c, act_ctl[0], act_busy[0]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    mem_busyM = 1;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (act_cnt[1] !== 16'd15 || act_cnt[0] !== 16'd20) begin
      errors++;
      $display("FAIL cnt_saturate: cnt4=%0d cnt16=%0d required 15/20", act_cnt[1], act_cnt[0]);
    end
    cnt_clr = 1;
    @(negedge clk);
    #1;
    checks++;
    if (act_cnt[1] !== 16'd0 || act_cnt[0] !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clr_wins: cnt4=%0d cnt16=%0d required 0/0", act_cnt[1], act_cnt[0]);
    end
    clear_inputs();
  endtask

  task automatic test_random(input int n);
    logic [6:0] e_ctl [2];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0 || $urandom_range(0, 199) == 0) begin
        rst_n = 0;
        ph[0] = 0; ph[1] = 0; scnt[0] = 0; scnt[1] = 0;
      end else begin
        rst_n = 1;
      end
      for (int i = 0; i < NRS; i++) begin
        rs_addrD[i*AW +: AW] = AW'($urandom_range(0, 3));
        rs_addrE[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      rs_useD   = NRS'($urandom);
      rd_addrE  = AW'($urandom_range(0, 3));
      rd_addrM  = AW'($urandom_range(0, 3));
      rd_addrW  = AW'($urandom_range(0, 3));
      rd_wrenE  = 1'($urandom);
      rd_wrenM  = 1'($urandom);
      rd_wrenW  = 1'($urandom);
      loadE     = 1'($urandom);
      br_takenE = ($urandom_range(0, 7) == 0);
      mc_startE = ($urandom_range(0, 5) == 0);
      mem_busyM = ($urandom_range(0, 7) == 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        e_ctl[k] = m_ctl(k);
        checks++;
        if (act_ctl[k] !== e_ctl[k]) begin
          errors++;
          $display("FAIL rnd_ctl inst%0d cyc%0d: got %b required %b", k, c, act_ctl[k], e_ctl[k]);
        end
        checks++;
        if (act_fwd[k] !== m_fwd(k)) begin
          errors++;
          $display("FAIL rnd_fwd inst%0d cyc%0d: got %b required %b", k, c, act_fwd[k], m_fwd(k));
        end
        checks++;
        if (act_busy[k] !== (ph[k] > 0)) begin
          errors++;
          $display("FAIL rnd_busy inst%0d cyc%0d: got %b required %b", k, c, act_busy[k], ph[k] > 0);
        end
        checks++;
        if (act_cnt[k] !== 16'(scnt[k])) begin
          errors++;
          $display("FAIL rnd_cnt inst%0d cyc%0d: got %0d required %0d", k, c, act_cnt[k], scnt[k]);
        end
      end
      @(posedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          if (!mem_busyM) begin
            if (ph[k] == 0) begin
              if (mc_startE && lat_k[k] > 0) ph[k] = lat_k[k];
            end else begin
              ph[k] = ph[k] - 1;
            end
          end
          if (cnt_clr)                             scnt[k] = 0;
          else if (e_ctl[k][6] && scnt[k] < max_k[k]) scnt[k] = scnt[k] + 1;
        end
      end
    end
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multicycle();
    test_mem_freeze();
    test_reset_busy();
    test_saturation();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter AW, default 5, register-address width.
REQ-002 SHALL provide parameter NRS, default 2, number of source-register ports per instruction.
REQ-003 SHALL provide parameter FWD_EN, default 1, forwarding enable (0 = stall-only interlock mode).
REQ-004 SHALL provide parameter MC_LAT, default 4, multi-cycle execute stall length in cycles (0 = feature disabled, legal 0..15).
REQ-005 SHALL provide parameter CW, default 16, width of the stall counter.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 Ports, in order:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  rs_addrD  in  NRS*AW  D-stage sources; port i at [i*AW +: AW]
  rs_useD  in  NRS  D-stage source-valid bits
  rs_addrE  in  NRS*AW  E-stage sources
  rd_addrE / rd_addrM / rd_addrW  in  AW each  destinations
  rd_wrenE / rd_wrenM / rd_wrenW  in  1 each  destination write enables
  loadE  in  1  E-stage instruction is a load
  br_takenE  in  1  redirect resolved in E
  mc_startE  in  1  E-stage instruction is multi-cycle
  mem_busyM  in  1  data memory not ready
  cnt_clr  in  1  synchronous clear of stall_cnt
  stallF / stallD / stallE / stallM  out  1 each  hold stage register
  flushD / flushE / flushM  out  1 each  bubble stage register
  fwd_sel  out  NRS*2  per E source: 00 regfile, 01 from M, 10 from W
  mc_busy  out  1  multi-cycle FSM in BUSY
  stall_cnt  out  CW  stalled-fetch cycle count

Function
REQ-008 Forwarding (FWD_EN=1): port i SHALL select 01 if rs_addrE[i]!=0, rd_wrenM=1 and rs_addrE[i]==rd_addrM; otherwise 10 on the same test against W; otherwise 00; M SHALL win over W.
REQ-009 With FWD_EN=0, fwd_sel SHALL be all zero.
REQ-010 Per-port RAW hazard i SHALL require rs_useD[i]=1 and rs_addrD[i]!=0.
REQ-011 With FWD_EN=1, the raw hazard SHALL be loadE & rd_wrenE & (rs_addrD[i]==rd_addrE) for any i.
REQ-012 With FWD_EN=0, the raw hazard SHALL be a match against any of E, M or W whose wren=1.
REQ-013 FSM states SHALL be IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-014 In IDLE with mc_startE=1, mem_busyM=0 and MC_LAT>0, the FSM SHALL go to BUSY and load cnt=MC_LAT-1.
REQ-015 In BUSY with mem_busyM=0: if cnt!=0, cnt SHALL decrement; if cnt==0, the FSM SHALL return to IDLE.
REQ-016 mem_busyM=1 SHALL freeze the state and cnt.
REQ-017 mc_stall SHALL be (IDLE & mc_startE & MC_LAT>0) | (BUSY & cnt!=0); the BUSY, cnt==0 cycle is the completion cycle and SHALL NOT stall.
REQ-018 mc_startE SHALL be ignored in BUSY.
REQ-019 Output priority, highest first, with all unlisted outputs at 0:
  (a) mem_busyM: stallF=stallD=stallE=stallM=1.
  (b) mc_stall: stallF=stallD=stallE=1, flushM=1.
  (c) br_takenE: flushD=flushE=1; the load-use stall SHALL be suppressed.
  (d) raw hazard: stallF=stallD=1, flushE=1.
REQ-020 Stall and flush outputs and fwd_sel SHALL be combinational with zero latency.
REQ-021 mc_busy SHALL equal (state==BUSY).
REQ-022 stall_cnt SHALL increment on every clock edge where stallF=1, SHALL saturate at all-ones, and SHALL be cleared by cnt_clr; cnt_clr SHALL win over increment.

Reset
REQ-023 rst_n=0 SHALL force, asynchronously, state=IDLE, cnt=0, stall_cnt=0 and mc_busy=0.
REQ-024 During reset, combinational outputs SHALL follow REQ-019 with state=IDLE.
REQ-025 Reset asserted while BUSY SHALL abort the operation; no residual stall after release.

Verification
REQ-026 rs_addrE[0]=5, rd_addrM=5, rd_wrenM=1, rd_addrW=5, rd_wrenW=1 -> fwd_sel[1:0]=01; with rs_addrE[0]=0 -> 00.
REQ-027 loadE=1, rd_wrenE=1, rd_addrE=7, rs_addrD[1]=7, rs_useD[1]=1 -> stallF=stallD=flushE=1 for one cycle; same stimulus with rs_useD[1]=0 -> no stall.
REQ-028 Same load-use as REQ-027 plus br_takenE=1 -> flushD=flushE=1, stallF=0.
REQ-029 MC_LAT=4, mc_startE held high -> stallE=1 for exactly 4 cycles, then 1 completion cycle with stallE=0 and mc_busy=1, then IDLE; stall_cnt=4.
REQ-030 mem_busyM=1 for 3 cycles in mid-BUSY -> all four stalls=1 and cnt frozen; total mc stall still 4 non-memory cycles.
REQ-031 rst_n=0 pulse during BUSY -> mc_busy=0 immediately; stall_cnt=0; mc_startE=0 after release -> no stalls.
